// File: rtl/dmem_resp.sv
// Data-memory responder for the MEM stage: word-aligned loads/stores with byte-masked
// writes and a fixed LATENCY wait-state model between accept and response.
module dmem_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic [31:0] i_dmem_mask,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              is_load_q, is_load_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       hold_q;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              accept;
    logic              unused_bits;

    assign idx          = i_dmem_addr[ADDR_W+1:2];
    assign o_dmem_ready = !i_rst && (state_q != S_WAIT);
    assign o_dmem_valid = !i_rst && (state_q == S_RESP);
    assign accept       = o_dmem_ready && (i_dmem_ren || i_dmem_wen);
    assign unused_bits  = ^{i_dmem_addr[31:ADDR_W+2], i_dmem_addr[1:0], i_dmem_mask[31:4]};

    // Load data is shown straight from the holding register during its response cycle,
    // and latched into rdata_q as the response retires so it persists afterwards.
    assign o_dmem_rdata = (o_dmem_valid && is_load_q) ? hold_q : rdata_q;

    // NOTE: the array and holding register have no reset so the array maps onto block RAM;
    // a store committed before a reset therefore survives it.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int b = 0; b < 4; b++) begin
                if (i_dmem_wen && i_dmem_mask[b]) begin
                    mem[idx][8*b +: 8] <= i_dmem_wdata[8*b +: 8];
                end
            end
            if (i_dmem_ren) begin
                hold_q <= mem[idx];
            end
        end
    end

    always_comb begin
        // NOTE: every next-state value gets a default first so no latch can be inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_load_d = is_load_q;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (state_q == S_RESP && is_load_q) begin
                    rdata_d = hold_q;
                end
                if (accept) begin
                    is_load_d = i_dmem_ren;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            is_load_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: three instances (LATENCY 1, 3, 4) checked against a plain
// word-array reference model with directed scenarios and randomized traffic.
module tb_dmem_resp;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst, ren, wen, rdy, vld;
    logic [31:0]  addr [N];
    logic [31:0]  wdata[N];
    logic [31:0]  mask [N];
    logic [31:0]  rdata[N];

    int errors = 0;
    int checks = 0;

    // Reference model: expected word contents and whether every byte is defined.
    bit [31:0] mdl  [N][1024];
    bit        known[N][1024];

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_resp #(
            .ADDR_W (10),
            .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst[g]),
            .i_dmem_ren  (ren[g]),
            .i_dmem_wen  (wen[g]),
            .i_dmem_addr (addr[g]),
            .i_dmem_wdata(wdata[g]),
            .i_dmem_mask (mask[g]),
            .o_dmem_ready(rdy[g]),
            .o_dmem_valid(vld[g]),
            .o_dmem_rdata(rdata[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    // Returns the pre-write word (what a load sees) and then applies the store.
    task automatic model_apply(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] m, output logic [31:0] exp_rd, output bit exp_known);
        int i;
        i = widx(a);
        exp_rd    = mdl[k][i];
        exp_known = known[k][i];
        if (w) begin
            for (int b = 0; b < 4; b++) begin
                if (m[b]) mdl[k][i][8*b +: 8] = d[8*b +: 8];
            end
            if (m[3:0] == 4'hF) known[k][i] = 1'b1;
        end
    endtask

    // One transaction; reports latency, data seen with valid, ready-high cycles while
    // waiting, and whether valid was still high one cycle after the response.
    task automatic xfer(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] m, output logic [31:0] got,
                        output int lat, output int rdy_bad, output bit pulse_long);
        int spin;
        spin = 0;
        @(negedge clk);
        ren[k] = r; wen[k] = w; addr[k] = a; wdata[k] = d; mask[k] = m;
        while (!rdy[k] && spin < 50) begin
            @(negedge clk);
            spin++;
        end
        @(posedge clk);
        @(negedge clk);
        ren[k] = 1'b0; wen[k] = 1'b0;
        lat = 1;
        rdy_bad = 0;
        while (!vld[k] && lat < 50) begin
            if (rdy[k]) rdy_bad++;
            @(negedge clk);
            lat++;
        end
        got = rdata[k];
        @(negedge clk);
        pulse_long = vld[k];
    endtask

    task automatic test_reset();
        rst = '1;
        repeat (3) @(negedge clk);
        checks++;
        if (vld !== 3'b000 || rdy !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b ready=%b, required valid=000 ready=000", vld, rdy);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (rdata[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_rdata[%0d]: got %h, required 00000000", k, rdata[k]);
            end
        end
        rst = '0;
        #1;
        checks++;
        if (rdy !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 111", rdy);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] got, exp;
        int lat, rb;
        bit pl, kn;
        model_apply(0, 1'b1, 32'h40, 32'hDEADBEEF, 32'hF, exp, kn);
        xfer(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'hF, got, lat, rb, pl);
        checks++;
        if (lat !== 1 || pl) begin
            errors++;
            $display("FAIL store_ack: latency=%0d long_pulse=%0b, required latency=1 long_pulse=0", lat, pl);
        end
        model_apply(0, 1'b0, 32'h40, 32'h0, 32'h0, exp, kn);
        xfer(0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, got, lat, rb, pl);
        checks++;
        if (lat !== 1 || pl || got !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_basic: latency=%0d long_pulse=%0b data=%h, required 1/0/deadbeef", lat, pl, got);
        end
    endtask

    task automatic test_byte_mask();
        logic [31:0] got, exp;
        int lat, rb;
        bit pl, kn;
        model_apply(0, 1'b1, 32'h80, 32'h11223344, 32'hF, exp, kn);
        xfer(0, 1'b0, 1'b1, 32'h80, 32'h11223344, 32'hF, got, lat, rb, pl);
        model_apply(0, 1'b1, 32'h80, 32'hAABBCCDD, 32'h5, exp, kn);
        xfer(0, 1'b0, 1'b1, 32'h80, 32'hAABBCCDD, 32'h5, got, lat, rb, pl);
        model_apply(0, 1'b0, 32'h80, 32'h0, 32'h0, exp, kn);
        xfer(0, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0, got, lat, rb, pl);
        checks++;
        if (got !== 32'h11BB33DD || got !== exp) begin
            errors++;
            $display("FAIL byte_mask: got %h, required 11bb33dd (model %h)", got, exp);
        end
    endtask

    task automatic test_latency3();
        logic [31:0] got, exp;
        int lat, rb;
        bit pl, kn;
        model_apply(1, 1'b1, 32'h20, 32'h12345678, 32'hF, exp, kn);
        xfer(1, 1'b0, 1'b1, 32'h20, 32'h12345678, 32'hF, got, lat, rb, pl);
        checks++;
        if (lat !== 3 || rb !== 0 || pl) begin
            errors++;
            $display("FAIL lat3_store: latency=%0d ready_high=%0d long_pulse=%0b, required 3/0/0", lat, rb, pl);
        end
        model_apply(1, 1'b0, 32'h20, 32'h0, 32'h0, exp, kn);
        xfer(1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, got, lat, rb, pl);
        checks++;
        if (lat !== 3 || rb !== 0 || pl || got !== 32'h12345678) begin
            errors++;
            $display("FAIL lat3_load: latency=%0d ready_high=%0d long_pulse=%0b data=%h, required 3/0/0/12345678",
                     lat, rb, pl, got);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp;
        int lat, rb;
        bit pl, kn;
        for (int i = 0; i < 3; i++) begin
            model_apply(0, 1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), 32'hF, exp, kn);
            xfer(0, 1'b0, 1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), 32'hF, got, lat, rb, pl);
        end
        @(negedge clk);
        ren[0] = 1'b1; wen[0] = 1'b0; addr[0] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < 2) addr[0] = 32'(4 * (i + 1));
            else ren[0] = 1'b0;
            checks++;
            if (vld[0] !== 1'b1 || rdata[0] !== mdl[0][i]) begin
                errors++;
                $display("FAIL b2b_load[%0d]: valid=%b data=%h, required valid=1 data=%h", i, vld[0], rdata[0], mdl[0][i]);
            end
        end
        @(negedge clk);
        checks++;
        if (vld[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: valid=%b, required 0", vld[0]);
        end
        // Store immediately followed by a load of the same word.
        ren[0] = 1'b0; wen[0] = 1'b1; addr[0] = 32'hC; wdata[0] = 32'h55AA55AA; mask[0] = 32'hF;
        model_apply(0, 1'b1, 32'hC, 32'h55AA55AA, 32'hF, exp, kn);
        @(posedge clk);
        @(negedge clk);
        wen[0] = 1'b0; ren[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ren[0] = 1'b0;
        checks++;
        if (vld[0] !== 1'b1 || rdata[0] !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL b2b_store_load: valid=%b data=%h, required valid=1 data=55aa55aa", vld[0], rdata[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_read_write_same();
        logic [31:0] got, exp;
        int lat, rb;
        bit pl, kn;
        model_apply(0, 1'b1, 32'h10, 32'h5, 32'hF, exp, kn);
        xfer(0, 1'b0, 1'b1, 32'h10, 32'h5, 32'hF, got, lat, rb, pl);
        model_apply(0, 1'b1, 32'h10, 32'h7, 32'hF, exp, kn);
        xfer(0, 1'b1, 1'b1, 32'h10, 32'h7, 32'hF, got, lat, rb, pl);
        checks++;
        if (got !== 32'h5 || lat !== 1 || pl) begin
            errors++;
            $display("FAIL rw_same_old: data=%h latency=%0d long_pulse=%0b, required 00000005/1/0", got, lat, pl);
        end
        xfer(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, got, lat, rb, pl);
        checks++;
        if (got !== 32'h7) begin
            errors++;
            $display("FAIL rw_same_new: data=%h, required 00000007", got);
        end
        // Zero mask: acknowledged, nothing written, rdata keeps last load value.
        model_apply(0, 1'b1, 32'h10, 32'hFFFFFFFF, 32'h0, exp, kn);
        xfer(0, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 32'hFFFF_FFF0, got, lat, rb, pl);
        checks++;
        if (lat !== 1 || got !== 32'h7) begin
            errors++;
            $display("FAIL zero_mask_ack: latency=%0d data=%h, required 1/00000007", lat, got);
        end
        xfer(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, got, lat, rb, pl);
        checks++;
        if (got !== 32'h7) begin
            errors++;
            $display("FAIL zero_mask_data: data=%h, required 00000007", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        int lat, rb, pulses;
        bit pl, kn;
        model_apply(2, 1'b1, 32'h0, 32'hCAFEF00D, 32'hF, exp, kn);
        xfer(2, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 32'hF, got, lat, rb, pl);
        xfer(2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, got, lat, rb, pl);
        checks++;
        if (lat !== 4 || rb !== 0 || got !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL lat4_load: latency=%0d ready_high=%0d data=%h, required 4/0/cafef00d", lat, rb, got);
        end
        @(negedge clk);
        ren[2] = 1'b1; addr[2] = 32'h4;
        @(posedge clk);
        @(negedge clk);
        ren[2] = 1'b0;
        rst[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst[2] = 1'b0;
        #1;
        checks++;
        if (vld[2] !== 1'b0 || rdata[2] !== 32'd0 || rdy[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: valid=%b data=%h ready=%b, required 0/00000000/1", vld[2], rdata[2], rdy[2]);
        end
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (vld[2]) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_dropped: saw %0d valid pulses, required 0", pulses);
        end
        model_apply(2, 1'b0, 32'h1000, 32'h0, 32'h0, exp, kn);
        xfer(2, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h0, got, lat, rb, pl);
        checks++;
        if (got !== 32'hCAFEF00D || got !== exp || lat !== 4) begin
            errors++;
            $display("FAIL alias_word0: data=%h latency=%0d, required cafef00d/4", got, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] got, exp, a, d, m, last_rd;
        int lat, rb, idx;
        bit pl, kn, r, w, have_last;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 8; i++) begin
                d = $urandom;
                model_apply(k, 1'b1, 32'(4 * i), d, 32'hF, exp, kn);
                xfer(k, 1'b0, 1'b1, 32'(4 * i), d, 32'hF, got, lat, rb, pl);
            end
            have_last = 1'b0;
            last_rd = '0;
            for (int n = 0; n < 30; n++) begin
                idx = int'($urandom_range(0, 7));
                a = ($urandom & 32'hFFFF_F000) | 32'(idx << 2) | ($urandom & 32'h3);
                d = $urandom;
                m = $urandom;
                case ($urandom_range(0, 2))
                    0: begin r = 1'b1; w = 1'b0; end
                    1: begin r = 1'b0; w = 1'b1; end
                    default: begin r = 1'b1; w = 1'b1; end
                endcase
                model_apply(k, w, a, d, m, exp, kn);
                xfer(k, r, w, a, d, m, got, lat, rb, pl);
                checks++;
                if (lat !== lat_of(k) || rb !== 0 || pl) begin
                    errors++;
                    $display("FAIL rand_timing[%0d/%0d]: latency=%0d ready_high=%0d long_pulse=%0b, required %0d/0/0",
                             k, n, lat, rb, pl, lat_of(k));
                end
                if (r && kn) begin
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL rand_load[%0d/%0d]: addr=%h data=%h, required %h", k, n, a, got, exp);
                    end
                    last_rd = exp;
                    have_last = 1'b1;
                end else if (!r && have_last) begin
                    checks++;
                    if (got !== last_rd) begin
                        errors++;
                        $display("FAIL rand_store_rdata[%0d/%0d]: data=%h, required held %h", k, n, got, last_rd);
                    end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = '1; ren = '0; wen = '0;
        for (int k = 0; k < N; k++) begin
            addr[k] = '0; wdata[k] = '0; mask[k] = '0;
        end
        test_reset();
        test_store_load();
        test_byte_mask();
        test_latency3();
        test_back_to_back();
        test_read_write_same();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
